axistream_forwarder: RTL and testbench
======================================

Name: axistream_forwarder

Overview:
Transmit-side counterpart of the AXI-Stream snooper. It claims a packet buffer that the filter has accepted, reads it word by word from packet memory, and emits it as an AXI-Stream packet with correct TKEEP/TLAST. It honours downstream TREADY backpressure and fixed memory read latency. It sits between the packet-memory read port and the egress AXI-Stream interface.

Parameters:
FWD_DATA_WIDTH, 64, memory word / TDATA width in bits (multiple of 8, power of 2)
FWD_ADDR_WIDTH, 9, packet-memory word address width
RD_LATENCY, 2, cycles from fwd_rd_en to valid fwd_rd_data (1..4)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >= RD_LATENCY+2)
LEN_WIDTH, FWD_ADDR_WIDTH+log2(FWD_DATA_WIDTH/8)+1, packet byte-length width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
rdy_for_fwd  in  1  a filtered packet is waiting in packet memory
rdy_for_fwd_ack  out  1  one-cycle pulse; forwarder has claimed the packet
fwd_byte_len  in  LEN_WIDTH  packet length in bytes; sampled on the ack cycle
fwd_addr  out  FWD_ADDR_WIDTH  packet-memory word address
fwd_rd_en  out  1  read strobe
fwd_rd_data  in  FWD_DATA_WIDTH  read data, valid RD_LATENCY cycles after fwd_rd_en
fwd_done  out  1  one-cycle pulse; last beat accepted downstream, buffer may be released
fwd_TDATA  out  FWD_DATA_WIDTH  stream data; byte i is at [8i+7:8i]
fwd_TKEEP  out  FWD_DATA_WIDTH/8  byte enables
fwd_TVALID  out  1  stream valid
fwd_TREADY  in  1  stream ready
fwd_TLAST  out  1  last beat of the packet

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: rdy_for_fwd_ack, fwd_rd_en, fwd_addr, fwd_done, fwd_TVALID, fwd_TLAST, fwd_TKEEP, fwd_TDATA. FIFO, read pipeline and counters are cleared. Reset mid-packet abandons the packet: no fwd_done, no further beats.
- Word arithmetic: BPW = FWD_DATA_WIDTH/8. nwords = ceil(len/BPW). rem = len mod BPW. Last-beat TKEEP = (rem==0) ? all ones : (1<<rem)-1. Every other beat has TKEEP all ones.
- FSM IDLE: if rdy_for_fwd, drive rdy_for_fwd_ack=1 for this cycle, latch len, and reset the word counter. Go to DONE if len==0, else READ.
- FSM READ:
  - Issue a read (fwd_rd_en=1, fwd_addr=word counter, starting at 0) only when inflight + fifo_count < FIFO_DEPTH. This credit rule means the FIFO never overflows.
  - The read pipeline (RD_LATENCY-deep shift register) carries valid, last and keep tags for each issued read. At the pipeline output, fwd_rd_data and the tags are pushed into the FIFO.
  - When the read for word nwords-1 is issued, go to DRAIN.
- FSM DRAIN: wait until the beat with TLAST is accepted (fwd_TVALID && fwd_TREADY), then go to DONE.
- FSM DONE: fwd_done=1 for exactly one cycle, then go to IDLE. rdy_for_fwd is not acknowledged in DONE, so the next claim occurs at the earliest one cycle after fwd_done.
- AXIS output comes from the FIFO head; fwd_TVALID = FIFO non-empty.
  - While fwd_TVALID && !fwd_TREADY, TDATA/TKEEP/TLAST are held stable.
  - A FIFO push and pop in the same cycle is legal and leaves the count unchanged.
- Latency: ack at cycle T, first read at T+1, first fwd_TVALID at T+2+RD_LATENCY.
- Throughput: with fwd_TREADY held at 1, one beat per cycle sustained.
- Ordering: beats are emitted in address order; no beat is dropped or duplicated under any TREADY pattern.
- fwd_TLAST is asserted only on the beat for word nwords-1.
- Length above the maximum: if len > 2^FWD_ADDR_WIDTH*BPW, it is clamped to the maximum. The read address never wraps.

Decomposition:
- Shared package (fwd_pkg): BPW, clog2 helper, keep_mask(rem) function, and FSM state encodings IDLE/READ/DRAIN/DONE.
- One sub-module: fwd_out_fifo, a synchronous FIFO of width FWD_DATA_WIDTH+BPW+1 and depth FIFO_DEPTH. It has push/pop/count and first-word-fall-through output.

Test Plan:
- 20-byte packet, BPW=8, TREADY=1 -> 3 beats with TKEEP FF,FF,0F and TLAST on beat 3. Beat 1 at ack+4 cycles (RD_LATENCY=2). fwd_done pulses 1 cycle after beat 3.
- 16-byte packet -> 2 beats, TKEEP FF,FF, TLAST on beat 2. fwd_addr goes 0 then 1, with exactly 2 fwd_rd_en pulses.
- 64-byte packet with TREADY pattern 1,0,0,1,0,1... -> 8 beats, TDATA equal to memory words 0..7 in order. Outputs stable whenever TVALID && !TREADY. fifo_count never exceeds 4.
- Zero-length packet -> ack pulse, no fwd_rd_en, no TVALID, fwd_done pulse 1 cycle after ack.
- rdy_for_fwd held high for two consecutive 9-byte packets -> second ack no earlier than 1 cycle after the first fwd_done. Second packet beats have TKEEP FF,01.
- rst low during beat 2 of a 40-byte packet -> all outputs 0 within the same cycle, no fwd_done. After release, a new packet is forwarded correctly from address 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the AXI-Stream transmit forwarder: FSM encoding,
// width helper and the last-beat byte-enable function.
package fwd_pkg;

    // Default data width; each instance derives its own bytes-per-word from
    // its FWD_DATA_WIDTH parameter, BPW is the value for the default build.
    localparam int FWD_DATA_WIDTH_DEF = 64;
    localparam int BPW                = FWD_DATA_WIDTH_DEF / 8;

    // Widest TKEEP keep_mask() can produce (1024-bit TDATA).
    localparam int MAX_BPW = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fwd_state_e;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Byte enables for the final beat: rem==0 means the word is full.
    // Callers truncate the result to their own TKEEP width.
    function automatic logic [MAX_BPW-1:0] keep_mask(input int unsigned rem);
        logic [MAX_BPW-1:0] m;
        if (rem == 0) m = '1;
        else          m = (MAX_BPW'(1) << rem) - MAX_BPW'(1);
        return m;
    endfunction

endpackage

// File: rtl/fwd_out_fifo.sv
// First-word-fall-through output FIFO. Head entry is visible on o_head
// whenever o_empty is low; push and pop in the same cycle keep the count.
module fwd_out_fifo
    import fwd_pkg::*;
#(
    parameter int  WIDTH = 73,
    parameter int  DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [AW:0]      o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axistream_forwarder.sv
// Claims an accepted packet buffer, streams it out of packet memory with a
// fixed read latency, and emits it on AXI-Stream with TKEEP/TLAST. Reads are
// credit-limited so the output FIFO can absorb every in-flight word.
module axistream_forwarder
    import fwd_pkg::*;
#(
    parameter int FWD_DATA_WIDTH = 64,
    parameter int FWD_ADDR_WIDTH = 9,
    parameter int RD_LATENCY     = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int LEN_WIDTH      = FWD_ADDR_WIDTH + clog2(FWD_DATA_WIDTH/8) + 1
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy_for_fwd,
    output logic                        rdy_for_fwd_ack,
    input  logic [LEN_WIDTH-1:0]        fwd_byte_len,
    output logic [FWD_ADDR_WIDTH-1:0]   fwd_addr,
    output logic                        fwd_rd_en,
    input  logic [FWD_DATA_WIDTH-1:0]   fwd_rd_data,
    output logic                        fwd_done,
    output logic [FWD_DATA_WIDTH-1:0]   fwd_TDATA,
    output logic [FWD_DATA_WIDTH/8-1:0] fwd_TKEEP,
    output logic                        fwd_TVALID,
    input  logic                        fwd_TREADY,
    output logic                        fwd_TLAST
);

    localparam int NB     = FWD_DATA_WIDTH / 8;
    localparam int LOG2NB = clog2(NB);
    localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W  = FWD_DATA_WIDTH + NB + 1;
    localparam int WC_W   = FWD_ADDR_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1) << (FWD_ADDR_WIDTH + LOG2NB);

    fwd_state_e r_state;
    fwd_state_e w_next;

    // Length decode (valid while rdy_for_fwd is presented in IDLE)
    logic [LEN_WIDTH-1:0]      w_len_clamp;
    logic [LEN_WIDTH-1:0]      w_len_rnd;
    logic [WC_W-1:0]           w_nwords;
    logic [NB-1:0]             w_last_keep;
    logic                      w_len_zero;

    // Per-packet state
    logic [FWD_ADDR_WIDTH-1:0] r_wcnt;
    logic [FWD_ADDR_WIDTH-1:0] r_last_idx;
    logic [NB-1:0]             r_last_keep;

    // Read pipeline tags, stage RD_LATENCY-1 lines up with fwd_rd_data
    logic [RD_LATENCY-1:0]         r_pipe_vld;
    logic [RD_LATENCY-1:0]         r_pipe_last;
    logic [RD_LATENCY-1:0][NB-1:0] r_pipe_keep;

    logic [CNT_W-1:0]          w_inflight;
    logic [CNT_W-1:0]          w_fifo_cnt;
    logic [CNT_W:0]            w_used;
    logic                      w_credit;
    logic                      w_issue_last;

    logic [ENT_W-1:0]          w_push_data;
    logic [ENT_W-1:0]          w_head;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_head_last;
    logic [NB-1:0]             w_head_keep;
    logic [FWD_DATA_WIDTH-1:0] w_head_data;

    assign w_len_clamp  = (fwd_byte_len > MAX_LEN) ? MAX_LEN : fwd_byte_len;
    assign w_len_rnd    = w_len_clamp + LEN_WIDTH'(NB - 1);
    assign w_nwords     = w_len_rnd[LEN_WIDTH-1:LOG2NB];
    assign w_last_keep  = NB'(keep_mask(32'(w_len_clamp) & 32'(NB - 1)));
    assign w_len_zero   = (fwd_byte_len == '0);

    assign w_issue_last = (r_wcnt == r_last_idx);
    assign w_used       = {1'b0, w_inflight} + {1'b0, w_fifo_cnt};
    assign w_credit     = (w_used < (CNT_W+1)'(FIFO_DEPTH));
    assign fwd_addr     = r_wcnt;

    // Count reads still travelling through the memory latency pipeline.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            w_inflight = w_inflight + CNT_W'(r_pipe_vld[i]);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (rdy_for_fwd) w_next = w_len_zero ? ST_DONE : ST_READ;
            ST_READ:  if (w_credit && w_issue_last) w_next = ST_DRAIN;
            ST_DRAIN: if (w_pop && w_head_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // FSM outputs; ack is gated by reset so it stays low while rst is held.
    always_comb begin
        rdy_for_fwd_ack = 1'b0;
        fwd_rd_en       = 1'b0;
        fwd_done        = 1'b0;
        case (r_state)
            ST_IDLE: rdy_for_fwd_ack = rdy_for_fwd && rst;
            ST_READ: fwd_rd_en       = w_credit;
            ST_DONE: fwd_done        = 1'b1;
            default: ;
        endcase
    end

    // Latch packet geometry on claim; advance the word address per read but
    // park it on the final word so it never wraps past the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt      <= '0;
            r_last_idx  <= '0;
            r_last_keep <= '0;
        end else if (rdy_for_fwd_ack) begin
            r_wcnt      <= '0;
            r_last_idx  <= FWD_ADDR_WIDTH'(w_nwords - WC_W'(1));
            r_last_keep <= w_last_keep;
        end else if (fwd_rd_en && !w_issue_last) begin
            r_wcnt      <= r_wcnt + FWD_ADDR_WIDTH'(1);
        end
    end

    // Tag pipeline matching the memory read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
            r_pipe_keep <= '0;
        end else begin
            r_pipe_vld[0]  <= fwd_rd_en;
            r_pipe_last[0] <= fwd_rd_en && w_issue_last;
            r_pipe_keep[0] <= w_issue_last ? r_last_keep : '1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
                r_pipe_keep[i] <= r_pipe_keep[i-1];
            end
        end
    end

    assign w_push_data = {r_pipe_last[RD_LATENCY-1], r_pipe_keep[RD_LATENCY-1], fwd_rd_data};
    assign w_pop       = fwd_TVALID && fwd_TREADY;

    fwd_out_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_pipe_vld[RD_LATENCY-1]),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_cnt),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    assign {w_head_last, w_head_keep, w_head_data} = w_head;

    // Stream outputs are forced to zero when no beat is presented, which
    // also gives all-zero outputs under reset.
    assign fwd_TVALID = !w_empty;
    assign fwd_TDATA  = fwd_TVALID ? w_head_data : '0;
    assign fwd_TKEEP  = fwd_TVALID ? w_head_keep : '0;
    assign fwd_TLAST  = fwd_TVALID && w_head_last;

endmodule

// File: tb/tb_axistream_forwarder.sv
// Scoreboard bench for axistream_forwarder: stimulus pushes expected beats,
// a negedge monitor compares every accepted beat and the control timing.
module tb_axistream_forwarder;

    localparam int DW = 64;
    localparam int AW = 9;
    localparam int RL = 2;
    localparam int FD = 4;
    localparam int NB = 8;
    localparam int LW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rdy_for_fwd = 1'b0;
    logic          rdy_for_fwd_ack;
    logic [LW-1:0] fwd_byte_len = '0;
    logic [AW-1:0] fwd_addr;
    logic          fwd_rd_en;
    logic [DW-1:0] fwd_rd_data;
    logic          fwd_done;
    logic [DW-1:0] fwd_TDATA;
    logic [NB-1:0] fwd_TKEEP;
    logic          fwd_TVALID;
    logic          fwd_TREADY = 1'b1;
    logic          fwd_TLAST;

    always #5 clk = ~clk;

    axistream_forwarder #(
        .FWD_DATA_WIDTH (DW),
        .FWD_ADDR_WIDTH (AW),
        .RD_LATENCY     (RL),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy_for_fwd     (rdy_for_fwd),
        .rdy_for_fwd_ack (rdy_for_fwd_ack),
        .fwd_byte_len    (fwd_byte_len),
        .fwd_addr        (fwd_addr),
        .fwd_rd_en       (fwd_rd_en),
        .fwd_rd_data     (fwd_rd_data),
        .fwd_done        (fwd_done),
        .fwd_TDATA       (fwd_TDATA),
        .fwd_TKEEP       (fwd_TKEEP),
        .fwd_TVALID      (fwd_TVALID),
        .fwd_TREADY      (fwd_TREADY),
        .fwd_TLAST       (fwd_TLAST)
    );

    // ---------------- packet memory model (fixed latency RL) ----------------
    logic [15:0]   mem_seed = 16'h0;
    logic [DW-1:0] mem_pipe [RL];

    function automatic logic [DW-1:0] word_of(input logic [15:0] seed, input int a);
        return {16'hC0DE, seed, 16'h0000, 16'(a)};
    endfunction

    always @(posedge clk) begin
        mem_pipe[0] <= word_of(mem_seed, int'(fwd_addr));
        for (int i = 1; i < RL; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign fwd_rd_data = mem_pipe[RL-1];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [NB-1:0] k;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int len, input logic [15:0] seed);
        beat_t b;
        int nw;
        int rem;
        nw  = (len + NB - 1) / NB;
        rem = len % NB;
        for (int i = 0; i < nw; i++) begin
            b.d = word_of(seed, i);
            b.l = (i == nw - 1);
            b.k = (b.l && rem != 0) ? NB'((1 << rem) - 1) : {NB{1'b1}};
            exp_q.push_back(b);
        end
    endtask

    // ---------------- TREADY driver ----------------
    int   cyc = 0;
    int   rdy_mode = 0;
    int   mode_start = 0;
    logic [5:0] pat = 6'b101001; // bit i = TREADY in pattern slot i: 1,0,0,1,0,1

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) fwd_TREADY = 1'b1;
        else               fwd_TREADY = pat[(cyc - mode_start) % 6];
    end

    // ---------------- monitor ----------------
    int    ack_cyc = 0, first_vld_cyc = 0, last_acc_cyc = 0, done_cyc = 0;
    int    rd_cnt = 0, acc_cnt = 0, done_cnt = 0, ack_cnt = 0, max_fifo = 0;
    bit    first_seen = 0, cur_zero = 0, hold = 0;
    logic [DW-1:0] prev_d;
    logic [NB-1:0] prev_k;
    logic          prev_l;
    beat_t         mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            hold = 0;
        end else begin
            if (rdy_for_fwd_ack) begin
                ack_cyc = cyc; ack_cnt++; rd_cnt = 0; acc_cnt = 0; first_seen = 0;
            end
            if (fwd_rd_en) begin
                check("rd_addr", 64'(fwd_addr), 64'(rd_cnt));
                rd_cnt++;
            end
            if (hold) begin
                check("hold_data", fwd_TDATA, prev_d);
                check("hold_ctl", {fwd_TVALID, fwd_TLAST, fwd_TKEEP}, {1'b1, prev_l, prev_k});
            end
            if (fwd_TVALID && !first_seen) begin
                first_seen = 1; first_vld_cyc = cyc;
            end
            if (fwd_TVALID && fwd_TREADY) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got data %h with no beat expected", fwd_TDATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", fwd_TDATA, mon_e.d);
                    check("beat_keep", 64'(fwd_TKEEP), 64'(mon_e.k));
                    check("beat_last", 64'(fwd_TLAST), 64'(mon_e.l));
                end
                acc_cnt++;
                if (fwd_TLAST) last_acc_cyc = cyc;
            end
            hold   = fwd_TVALID && !fwd_TREADY;
            prev_d = fwd_TDATA; prev_k = fwd_TKEEP; prev_l = fwd_TLAST;
            if (fwd_done) begin
                done_cnt++; done_cyc = cyc;
                if (cur_zero) check("done_after_ack", 64'(cyc - ack_cyc), 64'd1);
                else          check("done_after_last", 64'(cyc - last_acc_cyc), 64'd1);
            end
            if (int'(dut.u_fifo.o_count) > max_fifo) max_fifo = int'(dut.u_fifo.o_count);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"},   64'(rdy_for_fwd_ack), 64'd0);
        check({tag, "_rd_en"}, 64'(fwd_rd_en), 64'd0);
        check({tag, "_addr"},  64'(fwd_addr), 64'd0);
        check({tag, "_done"},  64'(fwd_done), 64'd0);
        check({tag, "_valid"}, 64'(fwd_TVALID), 64'd0);
        check({tag, "_last"},  64'(fwd_TLAST), 64'd0);
        check({tag, "_keep"},  64'(fwd_TKEEP), 64'd0);
        check({tag, "_data"},  fwd_TDATA, 64'd0);
    endtask

    task automatic claim(input int len);
        bit got;
        got = 0;
        fwd_byte_len = LW'(len);
        rdy_for_fwd  = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rdy_for_fwd_ack) got = 1;
        end
        @(posedge clk); #1;
        rdy_for_fwd = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout: got no ack expected ack within 50 cycles");
        end
    endtask

    task automatic wait_done(input int n0);
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk); #1;
            if (done_cnt > n0) got = 1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL done_timeout: got no fwd_done expected one within 300 cycles");
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n0;
        int d1;
        bit got;

        // Reset: outputs low even with a claim request pending
        rdy_for_fwd = 1'b1;
        #2;
        check_outputs_zero("reset");
        rdy_for_fwd = 1'b0;
        gap(3);
        rst = 1'b1;
        gap(2);

        // 20 bytes, TREADY=1: FF,FF,0F; first beat 4 cycles after ack
        mem_seed = 16'h0001; cur_zero = 0; n0 = done_cnt;
        push_exp(20, 16'h0001);
        claim(20);
        wait_done(n0);
        check("t1_latency", 64'(first_vld_cyc - ack_cyc), 64'd4);
        check("t1_reads", 64'(rd_cnt), 64'd3);
        check("t1_left", 64'(exp_q.size()), 64'd0);
        gap(3);

        // 16 bytes: two full beats, two reads at addresses 0,1
        mem_seed = 16'h0002; n0 = done_cnt;
        push_exp(16, 16'h0002);
        claim(16);
        wait_done(n0);
        check("t2_reads", 64'(rd_cnt), 64'd2);
        check("t2_left", 64'(exp_q.size()), 64'd0);
        gap(3);

        // 64 bytes under TREADY pattern 1,0,0,1,0,1
        mem_seed = 16'h0003; n0 = done_cnt;
        mode_start = cyc; rdy_mode = 1;
        push_exp(64, 16'h0003);
        claim(64);
        wait_done(n0);
        rdy_mode = 0;
        check("t3_reads", 64'(rd_cnt), 64'd8);
        check("t3_beats", 64'(acc_cnt), 64'd8);
        check("t3_left", 64'(exp_q.size()), 64'd0);
        gap(3);

        // Zero length: ack then done, no reads, no beats
        cur_zero = 1; n0 = done_cnt;
        claim(0);
        wait_done(n0);
        check("t4_reads", 64'(rd_cnt), 64'd0);
        check("t4_no_valid", 64'(first_seen), 64'd0);
        cur_zero = 0;
        gap(3);

        // Two 9-byte packets with rdy_for_fwd held high
        mem_seed = 16'h0005; n0 = done_cnt;
        push_exp(9, 16'h0005);
        push_exp(9, 16'h0005);
        fwd_byte_len = LW'(9);
        rdy_for_fwd  = 1'b1;
        wait_done(n0);
        d1 = done_cyc;
        wait_done(n0 + 1);
        rdy_for_fwd = 1'b0;
        check("t5_ack_gap_ok", 64'((ack_cyc - d1) >= 1), 64'd1);
        check("t5_acks", 64'(ack_cnt >= 2), 64'd1);
        check("t5_left", 64'(exp_q.size()), 64'd0);
        gap(3);

        // Reset while beat 2 of a 40-byte packet is presented
        mem_seed = 16'h0006; n0 = done_cnt;
        push_exp(40, 16'h0006);
        claim(40);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #2;
            if (fwd_TVALID && acc_cnt == 1) got = 1;
        end
        check("t6_beat2_seen", 64'(got), 64'd1);
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        gap(3);
        check("t6_no_done", 64'(done_cnt), 64'(n0));
        rst = 1'b1;
        gap(2);
        check("t6_no_done_after", 64'(done_cnt), 64'(n0));

        // Fresh 40-byte packet after reset starts from address 0
        mem_seed = 16'h0007; n0 = done_cnt;
        push_exp(40, 16'h0007);
        claim(40);
        wait_done(n0);
        check("t7_reads", 64'(rd_cnt), 64'd5);
        check("t7_left", 64'(exp_q.size()), 64'd0);
        gap(3);

        check("fifo_max_le_depth", 64'(max_fifo <= FD), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog in case a bounded wait itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
